// File: rtl/mycpu_pkg.sv
// Shared CPU-wide constants for the register file and its scoreboard.
package mycpu_pkg;
  localparam int REG_PC     = 15;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  // An alias index outside the register space switches the PC alias off.
  function automatic bit pc_alias_en(input int pc_reg, input int addr_w);
    return pc_reg < (1 << addr_w);
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on issue, cleared on writeback.
module reg_scoreboard
  import mycpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PC_REG = REG_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_iss_valid,
  input  logic [ADDR_W-1:0]     i_iss_addr,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_wa,
  output logic [2**ADDR_W-1:0]  o_pend,
  output logic [ADDR_W:0]       o_pend_cnt,
  output logic                  o_err
);
  localparam int              NREG   = 2**ADDR_W;
  localparam bit              PC_EN  = pc_alias_en(PC_REG, ADDR_W);
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_REG);

  logic [NREG-1:0] r_pend;
  logic            r_err;
  logic            w_iss_ok, w_wb_ok, w_dup;
  logic [NREG-1:0] w_set, w_clr;
  logic [ADDR_W:0] w_cnt;

  assign w_iss_ok = i_iss_valid & ~(PC_EN && (i_iss_addr == PC_IDX));
  assign w_wb_ok  = i_we & ~(PC_EN && (i_wa == PC_IDX));
  assign w_set    = w_iss_ok ? (NREG'(1) << i_iss_addr) : '0;
  assign w_clr    = w_wb_ok  ? (NREG'(1) << i_wa)       : '0;
  // A retiring load to the same register frees the slot, so re-issue is legal.
  assign w_dup    = w_iss_ok & r_pend[i_iss_addr] & ~(w_wb_ok && (i_wa == i_iss_addr));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      if (w_dup) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NREG; i++) w_cnt = w_cnt + (ADDR_W+1)'(r_pend[i]);
  end

  assign o_pend     = r_pend;
  assign o_pend_cnt = w_cnt;
  assign o_err      = r_err;
endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with PC alias, writeback bypass and load scoreboard stall.
module reg_file_sb
  import mycpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2,
  parameter int PC_REG = REG_PC,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] ra,
  input  logic [NRD-1:0]        rd_use,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rd_busy,
  output logic                  stall,
  input  logic [DATA_W-1:0]     pc_plus8,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wa,
  input  logic [DATA_W-1:0]     wd,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [ADDR_W:0]       pend_cnt,
  output logic                  err
);
  localparam int                NREG   = 2**ADDR_W;
  localparam bit                PC_EN  = pc_alias_en(PC_REG, ADDR_W);
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_REG);

  logic [DATA_W-1:0] r_mem [NREG];
  logic [NREG-1:0]   w_pend;
  logic              w_wb_ok;

  assign w_wb_ok = we & ~(PC_EN && (wa == PC_IDX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_wb_ok) begin
      r_mem[wa] <= wd;
    end
  end

  reg_scoreboard #(.ADDR_W(ADDR_W), .PC_REG(PC_REG)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_iss_valid(iss_valid),
    .i_iss_addr (iss_addr),
    .i_we       (we),
    .i_wa       (wa),
    .o_pend     (w_pend),
    .o_pend_cnt (pend_cnt),
    .o_err      (err)
  );

  // PC alias outranks bypass; a bypassed read also resolves a pending load.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_pc, w_byp;
    assign w_ra  = ra[p*ADDR_W +: ADDR_W];
    assign w_pc  = PC_EN && (w_ra == PC_IDX);
    assign w_byp = BYPASS && we && (wa == w_ra);
    assign rd[p*DATA_W +: DATA_W] = w_pc ? pc_plus8 : (w_byp ? wd : r_mem[w_ra]);
    assign rd_busy[p] = ~w_pc & w_pend[w_ra] & ~w_byp;
  end

  assign stall = |(rd_busy & rd_use);
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed table, corner sequences, randomized model compare.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]  ra;
  logic [1:0]  rd_use;
  logic [31:0] pc_plus8, wd;
  logic        we, iv;
  logic [3:0]  wa, ia;
  logic [63:0] rd_a, rd_b;
  logic [1:0]  busy_a, busy_b;
  logic        stall_a, stall_b, err_a, err_b;
  logic [4:0]  cnt_a, cnt_b;

  logic [14:0] ra3;
  logic [2:0]  use3, busy3;
  logic [95:0] rd3;
  logic        stall3, we3, iv3, err3;
  logic [31:0] pc3, wd3;
  logic [4:0]  wa3, ia3;
  logic [5:0]  cnt3;

  int errors = 0, checks = 0;

  reg_file_sb dut_a (.clk(clk), .reset(reset), .ra(ra), .rd_use(rd_use), .rd(rd_a),
    .rd_busy(busy_a), .stall(stall_a), .pc_plus8(pc_plus8), .we(we), .wa(wa), .wd(wd),
    .iss_valid(iv), .iss_addr(ia), .pend_cnt(cnt_a), .err(err_a));

  reg_file_sb #(.BYPASS(1'b0)) dut_b (.clk(clk), .reset(reset), .ra(ra), .rd_use(rd_use),
    .rd(rd_b), .rd_busy(busy_b), .stall(stall_b), .pc_plus8(pc_plus8), .we(we), .wa(wa),
    .wd(wd), .iss_valid(iv), .iss_addr(ia), .pend_cnt(cnt_b), .err(err_b));

  reg_file_sb #(.NRD(3), .ADDR_W(5), .PC_REG(31)) dut_c (.clk(clk), .reset(reset), .ra(ra3),
    .rd_use(use3), .rd(rd3), .rd_busy(busy3), .stall(stall3), .pc_plus8(pc3), .we(we3),
    .wa(wa3), .wd(wd3), .iss_valid(iv3), .iss_addr(ia3), .pend_cnt(cnt3), .err(err3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic we; logic [3:0] wa; logic [31:0] wd; logic iv; logic [3:0] ia;
    logic [3:0] ra0, ra1; logic [1:0] use_;
    logic [31:0] e0, e1; logic [1:0] ebusy; logic estall; logic [4:0] ecnt; logic eerr;
  } vec_t;

  function automatic vec_t mk(input int w, input int a, input int d, input int v, input int i,
                              input int r0, input int r1, input int u, input int e0,
                              input int e1, input int b, input int s, input int c, input int e);
    vec_t t;
    t.we = 1'(w); t.wa = 4'(a); t.wd = 32'(d); t.iv = 1'(v); t.ia = 4'(i);
    t.ra0 = 4'(r0); t.ra1 = 4'(r1); t.use_ = 2'(u);
    t.e0 = 32'(e0); t.e1 = 32'(e1); t.ebusy = 2'(b); t.estall = 1'(s);
    t.ecnt = 5'(c); t.eerr = 1'(e);
    return t;
  endfunction

  // Behavioural reference: architectural state as plain arrays.
  logic [31:0] mmem [16];
  bit          mpend [16];
  bit          merr;

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin mmem[i] = '0; mpend[i] = 0; end
    merr = 0;
  endtask

  function automatic logic [31:0] m_rd(input bit byp, input logic [3:0] a);
    if (a == 4'd15) return pc_plus8;
    if (byp && we && wa == a) return wd;
    return mmem[a];
  endfunction

  function automatic logic m_busy(input bit byp, input logic [3:0] a);
    if (a == 4'd15) return 1'b0;
    return mpend[a] && !(byp && we && wa == a);
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(mpend[i]);
    return n;
  endfunction

  task automatic m_step();
    if (iv && ia != 4'd15 && mpend[ia] && !(we && wa == ia)) merr = 1;
    if (we && wa != 4'd15) begin mmem[wa] = wd; mpend[wa] = 0; end
    if (iv && ia != 4'd15) mpend[ia] = 1;
  endtask

  task automatic m_check(input bit byp, input logic [63:0] r, input logic [1:0] b,
                         input logic s, input logic [4:0] c, input logic e);
    logic [1:0] eb;
    eb = {m_busy(byp, ra[7:4]), m_busy(byp, ra[3:0])};
    chk(byp ? "rnd_a rd0" : "rnd_b rd0", r[31:0],  m_rd(byp, ra[3:0]));
    chk(byp ? "rnd_a rd1" : "rnd_b rd1", r[63:32], m_rd(byp, ra[7:4]));
    chk(byp ? "rnd_a busy" : "rnd_b busy", 32'(b), 32'(eb));
    chk(byp ? "rnd_a stall" : "rnd_b stall", 32'(s), 32'(|(eb & rd_use)));
    chk(byp ? "rnd_a cnt" : "rnd_b cnt", 32'(c), 32'(m_cnt()));
    chk(byp ? "rnd_a err" : "rnd_b err", 32'(e), 32'(merr));
  endtask

  task automatic idle();
    we = 0; wa = '0; wd = '0; iv = 0; ia = '0;
  endtask

  vec_t tv[$];

  initial begin
    reset = 1'b1; idle(); ra = {4'd0, 4'd3}; rd_use = 2'b11; pc_plus8 = 32'h108;
    we3 = 0; wa3 = '0; wd3 = '0; iv3 = 0; ia3 = '0; ra3 = '0; use3 = '0; pc3 = 32'h2000;

    // Reset state
    @(posedge clk); #1;
    chk("rst rd0", rd_a[31:0], 32'h0);
    chk("rst cnt", 32'(cnt_a), 32'h0);
    chk("rst stall", 32'(stall_a), 32'h0);
    chk("rst err", 32'(err_a), 32'h0);
    reset = 1'b0;

    //          we wa wd           iv ia r0 r1 use  e0            e1     busy st cnt err
    tv.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0,  3, 15, 0, 32'hDEADBEEF, 32'h108, 0, 0, 0, 0));
    tv.push_back(mk(1, 15, 32'h55,      0, 0,  3, 15, 0, 32'hDEADBEEF, 32'h108, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0,            1, 4, 15, 15, 0, 32'h108,      32'h108, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0,            0, 0,  0,  4, 2, 0,            0,       2, 1, 1, 0));
    tv.push_back(mk(1, 4, 32'h44,       0, 0,  0,  4, 2, 0,            32'h44,  0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,            0, 0,  0,  4, 2, 0,            32'h44,  0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0,            1, 6,  6,  6, 0, 0,            0,       0, 0, 0, 0));
    tv.push_back(mk(1, 6, 32'h66,       1, 6,  6,  0, 1, 32'h66,       0,       0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,            0, 0,  6,  0, 1, 32'h66,       0,       1, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,            1, 6,  6,  0, 0, 32'h66,       0,       1, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,            0, 0,  6,  6, 3, 32'h66,       32'h66,  3, 1, 1, 1));
    tv.push_back(mk(0, 0, 0,            1, 15, 15, 6, 0, 32'h108,      32'h66,  2, 0, 1, 1));
    tv.push_back(mk(0, 0, 0,            0, 0, 15,  6, 1, 32'h108,      32'h66,  2, 0, 1, 1));
    tv.push_back(mk(1, 6, 32'h77,       0, 0,  6,  6, 3, 32'h77,       32'h77,  0, 0, 1, 1));

    foreach (tv[k]) begin
      we = tv[k].we; wa = tv[k].wa; wd = tv[k].wd; iv = tv[k].iv; ia = tv[k].ia;
      ra = {tv[k].ra1, tv[k].ra0}; rd_use = tv[k].use_;
      @(negedge clk);
      chk($sformatf("vec%0d rd0", k), rd_a[31:0], tv[k].e0);
      chk($sformatf("vec%0d rd1", k), rd_a[63:32], tv[k].e1);
      chk($sformatf("vec%0d busy", k), 32'(busy_a), 32'(tv[k].ebusy));
      chk($sformatf("vec%0d stall", k), 32'(stall_a), 32'(tv[k].estall));
      chk($sformatf("vec%0d cnt", k), 32'(cnt_a), 32'(tv[k].ecnt));
      chk($sformatf("vec%0d err", k), 32'(err_a), 32'(tv[k].eerr));
      @(posedge clk); #1;
    end

    // Issue r1, r2, r7 back to back, then reset in the middle of a cycle
    idle(); rd_use = 2'b11; iv = 1; ia = 4'd1;
    @(posedge clk); #1; ia = 4'd2;
    @(negedge clk); chk("seq cnt1", 32'(cnt_a), 32'd1);
    @(posedge clk); #1; ia = 4'd7;
    @(negedge clk); chk("seq cnt2", 32'(cnt_a), 32'd2);
    @(posedge clk); #1; iv = 0;
    @(negedge clk); chk("seq cnt3", 32'(cnt_a), 32'd3);
    #1 reset = 1'b1;
    #1;
    chk("midrst cnt", 32'(cnt_a), 32'd0);
    chk("midrst err", 32'(err_a), 32'd0);
    for (int r = 0; r < 15; r++) begin
      ra = {4'(r), 4'(r)}; #1;
      chk($sformatf("midrst r%0d", r), rd_a[31:0], 32'h0);
      chk($sformatf("midrst stall r%0d", r), 32'(stall_a), 32'h0);
    end
    @(posedge clk); #1 reset = 1'b0;

    // Bypass vs no bypass on the same traffic
    we = 1; wa = 4'd5; wd = 32'h1234; ra = {4'd5, 4'd5}; rd_use = 2'b00;
    @(negedge clk);
    chk("byp1 same-cycle", rd_a[31:0], 32'h1234);
    chk("byp0 same-cycle", rd_b[31:0], 32'h0);
    @(posedge clk); #1; idle();
    @(negedge clk);
    chk("byp0 next-cycle", rd_b[31:0], 32'h1234);
    @(posedge clk); #1; iv = 1; ia = 4'd9;
    @(posedge clk); #1; idle(); we = 1; wa = 4'd9; wd = 32'h99; ra = {4'd9, 4'd0}; rd_use = 2'b10;
    @(negedge clk);
    chk("byp1 wb stall", 32'(stall_a), 32'd0);
    chk("byp0 wb busy", 32'(busy_b), 32'd2);
    chk("byp0 wb stall", 32'(stall_b), 32'd1);
    @(posedge clk); #1; idle();
    @(negedge clk);
    chk("byp0 after busy", 32'(busy_b), 32'd0);
    chk("byp0 after cnt", 32'(cnt_b), 32'd0);
    chk("byp0 after rd1", rd_b[63:32], 32'h99);

    // Randomized traffic against the reference model
    @(posedge clk); #1 reset = 1'b1; idle();
    @(posedge clk); #1 reset = 1'b0; m_clear();
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      wd = $urandom;
      iv = ($urandom_range(0, 2) == 0);
      ia = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      ra = {(($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7))),
            (($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7)))};
      rd_use = 2'($urandom_range(0, 3));
      pc_plus8 = $urandom;
      @(negedge clk);
      m_check(1'b1, rd_a, busy_a, stall_a, cnt_a, err_a);
      m_check(1'b0, rd_b, busy_b, stall_b, cnt_b, err_b);
      if (n % 80 == 79) begin
        reset = 1'b1; m_clear(); #1;
        chk("rnd rst cnt", 32'(cnt_a), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
      end else begin
        @(posedge clk); m_step(); #1;
      end
    end
    idle();

    // Three read ports, 5-bit addresses, alias at r31
    we3 = 1; wa3 = 5'd20; wd3 = 32'hA5A51234;
    @(posedge clk); #1; wa3 = 5'd31; wd3 = 32'hFFFF; ra3 = {5'd20, 5'd20, 5'd20};
    @(negedge clk);
    for (int p = 0; p < 3; p++) chk($sformatf("nrd3 port%0d r20", p), rd3[p*32 +: 32], 32'hA5A51234);
    @(posedge clk); #1; we3 = 0; ra3 = {5'd31, 5'd20, 5'd31};
    @(negedge clk);
    chk("nrd3 port0 pc", rd3[31:0], 32'h2000);
    chk("nrd3 port1 r20", rd3[63:32], 32'hA5A51234);
    chk("nrd3 port2 pc", rd3[95:64], 32'h2000);
    @(posedge clk); #1; iv3 = 1; ia3 = 5'd20;
    @(posedge clk); #1; iv3 = 0; ra3 = {5'd20, 5'd20, 5'd20}; use3 = 3'b100;
    @(negedge clk);
    chk("nrd3 busy", 32'(busy3), 32'd7);
    chk("nrd3 stall", 32'(stall3), 32'd1);
    chk("nrd3 cnt", 32'(cnt3), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
